// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer
// Multi-cycle multiply/divide unit for the EX stage. A MULT/MULTU/DIV/DIVU
// held in EX is run as a 32-iteration shift-add multiply or restoring divide
// on operand magnitudes. Signs are applied in the FINISH cycle, and the result
// is committed to the architectural HI/LO registers. MTHI/MTLO writes are
// serviced while the unit is idle.
//
// Ports:
//   clk      pipeline clock, rising edge
//   reset_n  synchronous active-low reset
//   start    mul/div instruction present in EX (level)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   src_a    forwarded rs operand
//   src_b    forwarded rt operand
//   abort    EX flush; cancels the operation in flight
//   hi_we    MTHI write enable (honoured in IDLE only)
//   lo_we    MTLO write enable (honoured in IDLE only)
//   wr_data  MTHI/MTLO data
//   stall    freeze IF/ID/EX (combinational)
//   busy     unit not idle
//   done     high during the FINISH cycle
//   hi, lo   architectural HI/LO registers
module ex_muldiv_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        abort,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  count;
  logic [63:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] operand;  // mul: multiplicand magnitude; div: divisor magnitude
  logic        neg_a;
  logic        neg_b;
  logic        is_div;
  logic        b_zero;

  logic        accept;
  logic        signed_op;
  logic        sa_neg;
  logic        sb_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;

  logic [63:0] prod_res;
  logic [31:0] quot_res;
  logic [31:0] rem_res;

  assign accept    = (state == IDLE) && start && !abort;
  assign signed_op = !op[0];
  assign sa_neg    = signed_op && src_a[31];
  assign sb_neg    = signed_op && src_b[31];
  assign mag_a     = sa_neg ? (32'd0 - src_a) : src_a;
  assign mag_b     = sb_neg ? (32'd0 - src_b) : src_b;

  // Multiply step: add the multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole 64-bit register right. The
  // carry out of the add becomes the new top bit.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

  // Restoring divide step: shift the next dividend bit into the remainder.
  // A successful subtract keeps the difference and shifts a 1 into the
  // quotient. The shifted remainder needs 33 bits. A kept remainder is always
  // below the divisor, so it fits back into 32 bits.
  assign div_shift = acc[63:31];
  assign div_diff  = div_shift - {1'b0, operand};
  assign div_ge    = (div_shift >= {1'b0, operand});
  assign div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};

  // Sign fix-up applied in FINISH. The flags are already zero for unsigned ops.
  // For divide by zero, the restoring loop leaves the dividend magnitude as the
  // remainder. Giving it the dividend's sign reproduces src_a for DIV and DIVU.
  assign prod_res = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;
  assign quot_res = b_zero ? '1 : ((neg_a ^ neg_b) ? (32'd0 - acc[31:0]) : acc[31:0]);
  assign rem_res  = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = op[1] ? DIV_RUN : MUL_RUN;
      end
      MUL_RUN, DIV_RUN: begin
        if (abort)              state_nxt = IDLE;
        else if (count == 6'd31) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall = accept || (state == MUL_RUN) || (state == DIV_RUN);
    busy  = (state != IDLE);
    done  = (state == FINISH) && !abort;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      operand <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      is_div  <= 1'b0;
      b_zero  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wr_data;
          if (lo_we) lo <= wr_data;
          if (accept) begin
            is_div  <= op[1];
            neg_a   <= sa_neg;
            neg_b   <= sb_neg;
            b_zero  <= (src_b == 32'd0);
            count   <= '0;
            acc     <= {32'd0, (op[1] ? mag_a : mag_b)};
            operand <= op[1] ? mag_b : mag_a;
          end
        end
        MUL_RUN: begin
          count <= count + 6'd1;
          acc   <= mul_next;
        end
        DIV_RUN: begin
          count <= count + 6'd1;
          acc   <= div_next;
        end
        FINISH: begin
          if (!abort) begin
            if (is_div) begin
              hi <= rem_res;
              lo <= quot_res;
            end else begin
              hi <= prod_res[63:32];
              lo <= prod_res[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Testbench for ex_muldiv_sequencer: directed cases plus randomized mul/div
// operations. All results are compared against a plain-arithmetic reference model.
module tb_ex_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        abort;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ex_muldiv_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .abort   (abort),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wr_data (wr_data),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  // Reference behaviour: 64-bit integer arithmetic, truncated per half.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin pu = {32'd0, a} * {32'd0, b}; eh = pu[63:32]; el = pu[31:0]; end
      2'd2: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      default: begin
        if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
  endtask

  // Called during T0 before sampling. Checks T0..T33 and returns at T33 with
  // start still held.
  task automatic run_to_finish(input string tag);
    int unsigned n;
    sample;
    check({tag, "_t0_stall"}, stall, 1);
    check({tag, "_t0_busy"}, busy, 0);
    n = 0;
    do begin
      step;
      sample;
      n++;
      if (!done) begin
        check({tag, "_run_stall"}, stall, 1);
        check({tag, "_run_busy"}, busy, 1);
      end
    end while (!done && n < 40);
    check({tag, "_latency"}, n, 33);
    check({tag, "_fin_stall"}, stall, 0);
    check({tag, "_fin_busy"}, busy, 1);
  endtask

  // Drops start at T34 and checks the committed result.
  task automatic finish_and_check(input string tag, input logic [1:0] o,
                                  input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    model(o, a, b, eh, el);
    step;
    start = 1'b0;
    sample;
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_done_low"}, done, 0);
  endtask

  task automatic full_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b);
    step;
    issue(o, a, b);
    run_to_finish(tag);
    finish_and_check(tag, o, a, b);
  endtask

  initial begin
    logic [31:0] eh, el, rh, rl, ra, rb;
    logic [1:0]  ro;
    reset_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    step; step;
    sample;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    step;
    reset_n = 1'b1;

    full_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", lo, 32'h0000_0001);
    full_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
    full_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    full_op("divu_big", 2'd3, 32'hFFFF_FFF9, 32'd2);
    check("divu_big_lo_const", lo, 32'h7FFF_FFFC);
    full_op("div_zero", 2'd2, 32'h1234_5678, 32'd0);
    full_op("divu_zero", 2'd3, 32'h8765_4321, 32'd0);
    full_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", lo, 32'h8000_0000);

    // Reset in the middle of an operation.
    step;
    issue(2'd0, 32'd5, 32'd5);
    for (int i = 0; i < 10; i++) step;
    reset_n = 1'b0;
    step;
    sample;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_stall_start", stall, 1);
    step;
    start = 1'b0;
    sample;
    check("mid_rst_stall_nostart", stall, 0);
    reset_n = 1'b1;

    // Abort during RUN: HI/LO keep the values written by MTHI/MTLO.
    step;
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h1111_2222;
    step;
    hi_we = 1'b0; lo_we = 1'b0;
    issue(2'd0, 32'd5, 32'd5);
    begin
      bit seen_done = 0;
      for (int i = 0; i < 5; i++) begin
        step; sample;
        if (done) seen_done = 1;
      end
      step;
      abort = 1'b1;
      sample;
      if (done) seen_done = 1;
      step;
      abort = 1'b0; start = 1'b0;
      for (int i = 0; i < 40; i++) begin
        sample;
        if (done) seen_done = 1;
        if (i == 0) check("abort_idle", busy, 0);
        step;
      end
      check("abort_no_done", seen_done, 0);
    end
    sample;
    check("abort_hi", hi, 32'h1111_2222);
    check("abort_lo", lo, 32'h1111_2222);

    // abort in IDLE blocks the start.
    step;
    issue(2'd1, 32'd3, 32'd3);
    abort = 1'b1;
    sample;
    check("idle_abort_stall", stall, 0);
    step;
    start = 1'b0; abort = 1'b0;
    sample;
    check("idle_abort_busy", busy, 0);

    // Abort during FINISH: no commit, done suppressed.
    step;
    issue(2'd1, 32'd9, 32'd9);
    for (int i = 0; i < 33; i++) step;
    abort = 1'b1;
    sample;
    check("fin_abort_state", busy, 1);
    check("fin_abort_done", done, 0);
    step;
    abort = 1'b0; start = 1'b0;
    sample;
    check("fin_abort_busy", busy, 0);
    check("fin_abort_lo", lo, 32'h1111_2222);

    // MTLO in IDLE.
    step;
    lo_we = 1'b1; wr_data = 32'hDEAD_BEEF;
    step;
    lo_we = 1'b0;
    sample;
    check("mtlo_lo", lo, 32'hDEAD_BEEF);
    check("mtlo_hi", hi, 32'h1111_2222);

    // MTLO together with start. FINISH overwrites it, and start held through
    // FINISH must not trigger a second operation.
    step;
    issue(2'd1, 32'd6, 32'd7);
    lo_we = 1'b1; wr_data = 32'hCAFE_F00D;
    step;
    lo_we = 1'b0;
    sample;
    check("mtlo_start_lo", lo, 32'hCAFE_F00D);
    for (int i = 0; i < 32; i++) step;
    sample;
    check("mtlo_start_done", done, 1);
    finish_and_check("mtlo_start", 2'd1, 32'd6, 32'd7);
    step;
    sample;
    check("no_retrigger", busy, 0);

    // Back-to-back DIVU then MULTU. The second start is accepted at T34.
    step;
    issue(2'd3, 32'd100, 32'd7);
    run_to_finish("b2b_1");
    step;
    issue(2'd1, 32'd3, 32'd4);
    sample;
    check("b2b_1_lo", lo, 32'd14);
    check("b2b_1_hi", hi, 32'd2);
    check("b2b_t34_stall", stall, 1);
    step;
    sample;
    check("b2b_t35_busy", busy, 1);
    for (int i = 0; i < 32; i++) step;
    sample;
    check("b2b_2_done", done, 1);
    finish_and_check("b2b_2", 2'd1, 32'd3, 32'd4);
    check("b2b_2_lo_const", lo, 32'd12);

    // Randomized operations.
    for (int k = 0; k < 24; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 15);
      if ($urandom_range(0, 5) == 0) ra = $urandom_range(0, 100);
      full_op("rand", ro, ra, rb);
    end

    // Directed model spot-check to confirm the model's signed divide corner.
    model(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl);
    eh = hi; el = lo;
    full_op("rand_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("model_ovf_lo", lo, rl);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
